adder_sum_stage: RTL and testbench
==================================

// Module: adder_sum_stage
// PURPOSE
// - Final stage of the prefix adder pipeline. Consumes group-generate carries from the prefix tree plus raw
//   per-bit propagate, and produces registered sum, carry-out and ALU flags.
// - Valid/ready on both sides; a 2-entry skid buffer gives full throughput with a registered in_ready.
// - Sits between the prefix tree output and the ALU result mux.
// PARAMETERS
// - LEN       `LEN_DATA (32)  datapath width; must be >= 2
// PORTS
// - clk        in   1    single clock, rising edge
// - rst_n      in   1    asynchronous active-low reset
// - flush      in   1    synchronous drop of all buffered results
// - in_valid   in   1    upstream holds a valid operand set
// - in_ready   out  1    stage can accept this cycle (registered)
// - grp_gen    in   LEN  grp_gen[i] = G[i:0], Cin already folded in = carry into bit i+1
// - bit_prop   in   LEN  raw A[i]^B[i], bit 0 NOT OR-ed with Cin
// - cin        in   1    carry-in of the operation
// - out_valid  out  1    result available
// - out_ready  in   1    downstream accepts result
// - sum        out  LEN  A+B+Cin
// - cout       out  1    carry out of bit LEN-1
// - ovf        out  1    signed overflow
// - zero       out  1    sum == 0
// - neg        out  1    sum[LEN-1]
// BEHAVIOUR
// - Arithmetic (combinational, before capture):
//   sum[0] = bit_prop[0]^cin; sum[i] = bit_prop[i]^grp_gen[i-1] for i>=1
//   cout = grp_gen[LEN-1]; ovf = grp_gen[LEN-1]^grp_gen[LEN-2]; zero = ~|sum; neg = sum[LEN-1]
// - Storage: main reg (drives outputs) + skid reg, each holding {sum,cout,ovf,zero,neg}.
// - Handshakes: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
//   out_valid never drops, and output fields never change, while out_ready is low.
// - FSM on occupancy:
//   EMPTY: accept -> ONE (load main).
//   ONE:   accept & consume -> ONE (reload main); accept & ~consume -> FULL (load skid);
//          ~accept & consume -> EMPTY.
//   FULL:  in_ready=0; consume -> ONE (skid moves to main).
// - in_ready = (state != FULL) & ~flush; held as a register updated from next state.
// - Latency: accepted input appears on outputs the next cycle. Throughput: 1 result/cycle with out_ready high.
// - Order is strictly FIFO; no result is dropped or duplicated except by flush.
// - flush: next state EMPTY; out_valid=0 next cycle; an input offered in the flush cycle is not accepted
//   (in_ready is low). flush has priority over every simultaneous accept/consume.
// - Reset (rst_n low, async): state EMPTY, out_valid=0, in_ready=0 while asserted, 1 from the first clock after
//   release; sum=0, cout=0, ovf=0, zero=1, neg=0. Reset mid-transfer discards all buffered results.
// - Data regs need not reset for area, but outputs must show the reset values above (gate or reset main reg).
// STRUCTURE
// - define/main.def.v: `LEN_DATA; add `ADD_FLAGS_W (4) and flag bit indices (CF,VF,ZF,NF) for ALU reuse.
// - One sub-module: adder_sum_calc (combinational sum/flag logic above), so the same equations feed the
//   unpipelined ALU path. FSM and skid buffer stay in adder_sum_stage.
// TESTING
// - Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, zero=1, sum=0; in_ready=1 one clock after release.
// - Arith, LEN=32: A=0xFFFFFFFF, B=1, cin=0 -> sum=0, cout=1, zero=1, ovf=0; A=0x7FFFFFFF, B=1 ->
//   sum=0x80000000, ovf=1, neg=1, cout=0; A=B=0, cin=1 -> sum=1 (checks bit-0 cin path).
// - Streaming: 100 random ops, out_ready=1 -> one result per cycle, latency 1, matches A+B+cin in order.
// - Backpressure: out_ready=0 for 4 cycles while in_valid=1 -> exactly 2 accepted, in_ready=0, outputs stable;
//   release -> both drained in order, then streaming resumes without loss.
// - Flush in FULL with in_valid=1 -> next cycle out_valid=0, offered item not accepted, no stale result later.
// - Async reset pulse mid-stream (between clock edges) -> out_valid falls immediately; post-reset outputs clean.

Source files
------------

// File: rtl/adder_sum_stage_pkg.sv
// Shared widths, ALU flag layout and occupancy states for the adder sum stage.
package adder_sum_stage_pkg;

    localparam int unsigned LEN_DATA    = 32;
    localparam int unsigned ADD_FLAGS_W = 4;

    // Flag bit positions, shared with the unpipelined ALU path
    localparam int unsigned FLAG_CF = 0;
    localparam int unsigned FLAG_VF = 1;
    localparam int unsigned FLAG_ZF = 2;
    localparam int unsigned FLAG_NF = 3;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } occ_e;

endpackage

// File: rtl/adder_sum_calc.sv
// Combinational sum and flag generation from prefix-tree carries and raw propagate.
module adder_sum_calc
    import adder_sum_stage_pkg::*;
#(
    parameter int unsigned LEN = LEN_DATA
) (
    input  logic [LEN-1:0]         grp_gen,
    input  logic [LEN-1:0]         bit_prop,
    input  logic                   cin,
    output logic [LEN-1:0]         sum,
    output logic [ADD_FLAGS_W-1:0] flags
);

    always_comb begin
        // Carry into bit i is grp_gen[i-1]; bit 0 takes cin directly
        sum            = bit_prop ^ {grp_gen[LEN-2:0], cin};
        flags          = '0;
        flags[FLAG_CF] = grp_gen[LEN-1];
        flags[FLAG_VF] = grp_gen[LEN-1] ^ grp_gen[LEN-2];
        flags[FLAG_ZF] = ~|sum;
        flags[FLAG_NF] = sum[LEN-1];
    end

endmodule

// File: rtl/adder_sum_stage.sv
// Registered final adder stage with valid/ready handshakes and a 2-entry skid buffer.
module adder_sum_stage
    import adder_sum_stage_pkg::*;
#(
    parameter int unsigned LEN = LEN_DATA
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [LEN-1:0] grp_gen,
    input  logic [LEN-1:0] bit_prop,
    input  logic           cin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [LEN-1:0] sum,
    output logic           cout,
    output logic           ovf,
    output logic           zero,
    output logic           neg
);

    occ_e                   state_q, state_d;
    logic                   in_ready_q;
    logic [LEN-1:0]         main_sum_q, main_sum_d, skid_sum_q, skid_sum_d;
    logic [ADD_FLAGS_W-1:0] main_flags_q, main_flags_d, skid_flags_q, skid_flags_d;
    logic [LEN-1:0]         calc_sum;
    logic [ADD_FLAGS_W-1:0] calc_flags;
    logic                   accept, consume;

    adder_sum_calc #(
        .LEN (LEN)
    ) u_calc (
        .grp_gen  (grp_gen),
        .bit_prop (bit_prop),
        .cin      (cin),
        .sum      (calc_sum),
        .flags    (calc_flags)
    );

    // flush masks the registered ready so an offer in the flush cycle is refused
    assign in_ready  = in_ready_q & ~flush;
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        main_sum_d   = main_sum_q;
        main_flags_d = main_flags_q;
        skid_sum_d   = skid_sum_q;
        skid_flags_d = skid_flags_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d      = StOne;
                        main_sum_d   = calc_sum;
                        main_flags_d = calc_flags;
                    end
                end
                StOne: begin
                    if (accept && consume) begin
                        main_sum_d   = calc_sum;
                        main_flags_d = calc_flags;
                    end else if (accept) begin
                        state_d      = StFull;
                        skid_sum_d   = calc_sum;
                        skid_flags_d = calc_flags;
                    end else if (consume) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (consume) begin
                        state_d      = StOne;
                        main_sum_d   = skid_sum_q;
                        main_flags_d = skid_flags_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            in_ready_q   <= 1'b0;
            main_sum_q   <= '0;
            main_flags_q <= ADD_FLAGS_W'(1) << FLAG_ZF;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= (state_d != StFull);
            main_sum_q   <= main_sum_d;
            main_flags_q <= main_flags_d;
        end
    end

    // Skid contents are only observed after being loaded, so no reset is needed
    always_ff @(posedge clk) begin
        skid_sum_q   <= skid_sum_d;
        skid_flags_q <= skid_flags_d;
    end

    assign sum  = main_sum_q;
    assign cout = main_flags_q[FLAG_CF];
    assign ovf  = main_flags_q[FLAG_VF];
    assign zero = main_flags_q[FLAG_ZF];
    assign neg  = main_flags_q[FLAG_NF];

endmodule

// File: tb/tb_adder_sum_stage.sv
// Self-checking bench for adder_sum_stage: directed arithmetic table plus handshake sequences.
module tb_adder_sum_stage;

    localparam int unsigned LEN = 32;

    logic           clk = 1'b0;
    logic           rst_n, flush, in_valid, in_ready, cin, out_valid, out_ready;
    logic [LEN-1:0] grp_gen, bit_prop, sum;
    logic           cout, ovf, zero, neg;

    int n_checks = 0;
    int n_errors = 0;

    logic [LEN+3:0] exp_q[$];
    int             acc_cnt;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
        logic        e_zero;
        logic        e_neg;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    adder_sum_stage #(
        .LEN (LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .grp_gen   (grp_gen),
        .bit_prop  (bit_prop),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Ripple carries stand in for the upstream prefix tree
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic cy;
        cy = c;
        for (int i = 0; i < LEN; i++) begin
            grp_gen[i] = (a[i] & b[i]) | ((a[i] ^ b[i]) & cy);
            cy         = grp_gen[i];
        end
        bit_prop = a ^ b;
        cin      = c;
    endtask

    function automatic logic [LEN+3:0] model(input logic [31:0] a, input logic [31:0] b,
                                             input logic c);
        logic [32:0] s;
        logic        v;
        s = {1'b0, a} + {1'b0, b} + {32'd0, c};
        v = (a[31] == b[31]) && (s[31] != a[31]);
        return {s[31:0], s[31], (s[31:0] == 32'd0), v, s[32]};
    endfunction

    function automatic logic [LEN+3:0] outs();
        return {sum, neg, zero, ovf, cout};
    endfunction

    // One cycle: drive at negedge, then score what the coming posedge will transfer
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        out_ready = rdy;
        drive(a, b, c);
        #1;
        check("out_valid_vs_model", {63'd0, out_valid}, {63'd0, (exp_q.size() != 0)});
        if (out_valid && out_ready && exp_q.size() != 0) begin
            check("result_order", {28'd0, outs()}, {28'd0, exp_q[0]});
            void'(exp_q.pop_front());
        end
        if (v && in_ready) begin
            exp_q.push_back(model(a, b, c));
            acc_cnt++;
        end
    endtask

    initial begin
        logic [LEN+3:0] held;
        int             budget;

        vecs[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h0, 32'h0, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset held with an offer pending
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        drive(32'h1234, 32'h1, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_zero", {63'd0, zero}, 64'd1);
        check("rst_sum", {32'd0, sum}, 64'd0);
        check("rst_flags", {61'd0, cout, ovf, neg}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
        check("idle_after_rst", {63'd0, out_valid}, 64'd0);

        // Directed arithmetic table, latency 1
        foreach (vecs[k]) begin
            @(negedge clk);
            in_valid = 1'b1;
            drive(vecs[k].a, vecs[k].b, vecs[k].c);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d_valid", k), {63'd0, out_valid}, 64'd1);
            check($sformatf("v%0d_sum", k), {32'd0, sum}, {32'd0, vecs[k].e_sum});
            check($sformatf("v%0d_cout", k), {63'd0, cout}, {63'd0, vecs[k].e_cout});
            check($sformatf("v%0d_ovf", k), {63'd0, ovf}, {63'd0, vecs[k].e_ovf});
            check($sformatf("v%0d_zero", k), {63'd0, zero}, {63'd0, vecs[k].e_zero});
            check($sformatf("v%0d_neg", k), {63'd0, neg}, {63'd0, vecs[k].e_neg});
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Streaming, full throughput
        acc_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        end
        check("stream_accepts", 64'(acc_cnt), 64'd100);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: four stalled cycles, only two fit
        acc_cnt = 0;
        step(1'b1, 32'hA, 32'h1, 1'b0, 1'b0);
        step(1'b1, 32'hB, 32'h2, 1'b0, 1'b0);
        held = outs();
        step(1'b1, 32'hC, 32'h3, 1'b0, 1'b0);
        check("bp_in_ready_c3", {63'd0, in_ready}, 64'd0);
        check("bp_stable_c3", {28'd0, outs()}, {28'd0, held});
        step(1'b1, 32'hC, 32'h3, 1'b0, 1'b0);
        check("bp_in_ready_c4", {63'd0, in_ready}, 64'd0);
        check("bp_stable_c4", {28'd0, outs()}, {28'd0, held});
        check("bp_accepts", 64'(acc_cnt), 64'd2);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h100 + 32'(i), 32'hFFFF_FF00, 1'b1, 1'b1);
        end
        budget = 0;
        while (exp_q.size() != 0 && budget < 8) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            budget++;
        end
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Flush while full with an offer pending
        step(1'b1, 32'h11, 32'h22, 1'b0, 1'b0);
        step(1'b1, 32'h33, 32'h44, 1'b0, 1'b0);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        drive(32'h55, 32'h66, 1'b0);
        #1;
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        exp_q.delete();
        #1;
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h7, 32'h8, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("flush_recovered", 64'(exp_q.size()), 64'd0);

        // Async reset pulse between edges mid-stream
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hDEAD_0000 + 32'(i), 32'h0F0F_0F0F, 1'b0, 1'b1);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_sum", {32'd0, sum}, 64'd0);
        check("arst_zero", {63'd0, zero}, 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h8000_0000 + 32'(i), 32'h7FFF_FFFF, 1'(i), 1'b1);
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("arst_recovered", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

endmodule
